// File: rtl/svca_multi.sv
// Multi-channel voltage-controlled amplifier: one shared multiplier is time-multiplexed
// across channels per frame, with per-channel gain slew limiting and unipolar/bipolar modes.
module svca_multi #(
  parameter int CHANNELS  = 4,
  parameter int DW        = 8,
  parameter int CW        = 8,
  parameter int SLEW_STEP = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sample_stb,
  input  logic [CHANNELS*DW-1:0] sig_in,
  input  logic [CHANNELS*CW-1:0] cv_in,
  input  logic                   bipolar,
  output logic [CHANNELS*DW-1:0] sig_out,
  output logic                   out_valid,
  output logic                   busy,
  output logic                   overrun
);
  // Handshake: sample_stb is a single-cycle request, accepted only while idle (busy=0);
  // out_valid is a single-cycle pulse and a new sample_stb may coincide with it.
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int PW   = DW + CW + 2;
  localparam logic [CW:0]          STEP   = (CW+1)'(SLEW_STEP);
  localparam logic [CW-1:0]        G_FULL = '1;
  localparam logic [DW-1:0]        MID_D  = DW'(1) << (DW-1);
  localparam logic signed [DW:0]   MID_S  = {1'b0, MID_D};

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
  state_t state, state_nxt;

  logic [CHANNELS*DW-1:0] sh_sig;
  logic [CHANNELS*CW-1:0] sh_cv;
  logic                   sh_bip;
  logic [CW-1:0]          gain [CHANNELS];
  logic [CH_W-1:0]        ch;
  logic                   last_ch;

  logic [CW-1:0]          g_cur, c_cur, g_new;
  logic [CW:0]            g_ext, c_ext;
  logic [DW-1:0]          s_cur;
  logic signed [DW:0]     s_op;
  logic signed [PW-1:0]   prod_nxt;

  logic                   p_vld, p_unity;
  logic [CH_W-1:0]        p_ch;
  logic signed [PW-1:0]   p_prod;
  logic [DW-1:0]          wb_prod, wb_val;
  logic [CHANNELS*DW-1:0] stage, stage_nxt;

  assign last_ch = (ch == CH_W'(CHANNELS-1));
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sample_stb) state_nxt = RUN;
      RUN:     if (last_ch)    state_nxt = FLUSH;
      FLUSH:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Gain update works in CW+1 bits so stepping never wraps past 0 or full scale.
  always_comb begin
    g_cur = gain[ch];
    c_cur = sh_cv[ch*CW +: CW];
    g_ext = {1'b0, g_cur};
    c_ext = {1'b0, c_cur};
    g_new = g_cur;
    if (SLEW_STEP == 0)     g_new = c_cur;
    else if (c_ext > g_ext) g_new = ((c_ext - g_ext) > STEP) ? CW'(g_ext + STEP) : c_cur;
    else if (c_ext < g_ext) g_new = ((g_ext - c_ext) > STEP) ? CW'(g_ext - STEP) : c_cur;
  end

  // Bipolar samples are re-centred around zero so one signed multiply serves both modes.
  always_comb begin
    s_cur    = sh_sig[ch*DW +: DW];
    s_op     = sh_bip ? ($signed({1'b0, s_cur}) - MID_S) : $signed({1'b0, s_cur});
    prod_nxt = s_op * $signed({1'b0, g_new});
  end

  // Full-scale gain passes the sample through untouched; the shift alone would lose one LSB.
  always_comb begin
    wb_prod   = DW'(p_prod >>> CW);
    wb_val    = p_unity ? sh_sig[p_ch*DW +: DW] : (wb_prod + (sh_bip ? MID_D : '0));
    stage_nxt = stage;
    if (p_vld) stage_nxt[p_ch*DW +: DW] = wb_val;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_sig    <= '0;
      sh_cv     <= '0;
      sh_bip    <= 1'b0;
      for (int k = 0; k < CHANNELS; k++) gain[k] <= '0;
      ch        <= '0;
      p_vld     <= 1'b0;
      p_unity   <= 1'b0;
      p_ch      <= '0;
      p_prod    <= '0;
      stage     <= '0;
      sig_out   <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      p_vld     <= 1'b0;
      out_valid <= (state == FLUSH);
      overrun   <= sample_stb && (state != IDLE);
      stage     <= stage_nxt;
      if (state == IDLE) begin
        ch <= '0;
        if (sample_stb) begin
          sh_sig <= sig_in;
          sh_cv  <= cv_in;
          sh_bip <= bipolar;
        end
      end
      if (state == RUN) begin
        gain[ch] <= g_new;
        p_prod   <= prod_nxt;
        p_unity  <= (g_new == G_FULL);
        p_ch     <= ch;
        p_vld    <= 1'b1;
        ch       <= last_ch ? '0 : ch + 1'b1;
      end
      if (state == FLUSH) sig_out <= stage_nxt;
    end
  end
endmodule

// File: tb/tb_svca_multi.sv
// Directed bench for svca_multi: a bypass-slew instance (u0) and a SLEW_STEP=16 instance (u1)
// share clock, reset and stimulus; each step checks hand-computed values.
module tb_svca_multi;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sample_stb = 1'b0;
  logic [31:0] sig_in = '0;
  logic [31:0] cv_in = '0;
  logic        bipolar = 1'b0;
  logic [31:0] sig_out0, sig_out1;
  logic        out_valid0, out_valid1, busy0, busy1, overrun0, overrun1;

  int checks = 0;
  int failures = 0;

  svca_multi #(.CHANNELS(4), .DW(8), .CW(8), .SLEW_STEP(0)) u0 (
    .clk(clk), .rst_n(rst_n), .sample_stb(sample_stb), .sig_in(sig_in), .cv_in(cv_in),
    .bipolar(bipolar), .sig_out(sig_out0), .out_valid(out_valid0), .busy(busy0),
    .overrun(overrun0));

  svca_multi #(.CHANNELS(4), .DW(8), .CW(8), .SLEW_STEP(16)) u1 (
    .clk(clk), .rst_n(rst_n), .sample_stb(sample_stb), .sig_in(sig_in), .cv_in(cv_in),
    .bipolar(bipolar), .sig_out(sig_out1), .out_valid(out_valid1), .busy(busy1),
    .overrun(overrun1));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issues one frame and waits (bounded) for u0's out_valid; latency must be 6 cycles.
  task automatic run_frame(input logic [31:0] s, input logic [31:0] c, input logic b);
    int n;
    sig_in = s;
    cv_in = c;
    bipolar = b;
    sample_stb = 1'b1;
    tick();
    sample_stb = 1'b0;
    n = 1;
    while (!out_valid0 && n < 20) begin
      tick();
      n++;
    end
    check("frame_latency", 64'(n), 64'd6);
  endtask

  initial begin
    int gm;
    int pulses;
    logic [7:0] e;

    // Reset values
    tick();
    tick();
    check("rst_sig_out", sig_out0, 32'h0);
    check("rst_out_valid", out_valid0, 1'b0);
    check("rst_busy", busy0, 1'b0);
    check("rst_overrun", overrun0, 1'b0);
    rst_n = 1'b1;
    tick();

    // Latency and unity gain, unipolar: sig {255,200,1,0} (ch3..ch0)
    sig_in = {8'd255, 8'd200, 8'd1, 8'd0};
    cv_in = {4{8'd255}};
    bipolar = 1'b0;
    sample_stb = 1'b1;
    check("lat_busy_c0", busy0, 1'b0);
    for (int cyc = 1; cyc <= 8; cyc++) begin
      tick();
      if (cyc == 1) sample_stb = 1'b0;
      check($sformatf("lat_out_valid_c%0d", cyc), out_valid0, (cyc == 6));
      check($sformatf("lat_busy_c%0d", cyc), busy0, (cyc >= 1 && cyc <= 5));
      if (cyc == 6) check("lat_unity_sig_out", sig_out0, {8'd255, 8'd200, 8'd1, 8'd0});
    end

    // Half and mixed gains, slew bypass
    run_frame({4{8'd255}}, {4{8'd128}}, 1'b0);
    check("uni_half", sig_out0, {4{8'd127}});
    run_frame({8'd0, 8'd255, 8'd0, 8'd255}, {4{8'd128}}, 1'b1);
    check("bip_half", sig_out0, {8'd64, 8'd191, 8'd64, 8'd191});
    run_frame({8'd0, 8'd255, 8'd17, 8'd200}, {4{8'd0}}, 1'b1);
    check("bip_zero_gain", sig_out0, {4{8'd128}});
    run_frame({8'd0, 8'd1, 8'd255, 8'd128}, {4{8'd255}}, 1'b1);
    check("bip_unity", sig_out0, {8'd0, 8'd1, 8'd255, 8'd128});
    run_frame({4{8'd200}}, {8'd255, 8'd128, 8'd64, 8'd0}, 1'b0);
    check("uni_mixed", sig_out0, {8'd200, 8'd100, 8'd50, 8'd0});
    tick();
    check("hold_sig_out", sig_out0, {8'd200, 8'd100, 8'd50, 8'd0});

    // Overrun: second strobe two cycles after the first is ignored
    sig_in = {8'd10, 8'd20, 8'd30, 8'd40};
    cv_in = {4{8'd255}};
    bipolar = 1'b0;
    sample_stb = 1'b1;
    for (int cyc = 1; cyc <= 9; cyc++) begin
      tick();
      if (cyc == 1 || cyc == 3) sample_stb = 1'b0;
      check($sformatf("ovr_overrun_c%0d", cyc), overrun0, (cyc == 3));
      check($sformatf("ovr_out_valid_c%0d", cyc), out_valid0, (cyc == 6));
      if (cyc == 6) check("ovr_sig_out", sig_out0, {8'd10, 8'd20, 8'd30, 8'd40});
      if (cyc == 2) begin
        sample_stb = 1'b1;
        sig_in = {4{8'd99}};
        cv_in = {4{8'd0}};
        bipolar = 1'b1;
      end
    end

    // Back-to-back: strobe in the out_valid cycle is accepted without overrun
    sig_in = {8'd1, 8'd2, 8'd3, 8'd4};
    cv_in = {4{8'd255}};
    bipolar = 1'b0;
    sample_stb = 1'b1;
    for (int cyc = 1; cyc <= 13; cyc++) begin
      tick();
      if (cyc == 1 || cyc == 7) sample_stb = 1'b0;
      check($sformatf("b2b_out_valid_c%0d", cyc), out_valid0, (cyc == 6 || cyc == 12));
      check($sformatf("b2b_overrun_c%0d", cyc), overrun0, 1'b0);
      if (cyc == 6) begin
        check("b2b_first", sig_out0, {8'd1, 8'd2, 8'd3, 8'd4});
        sample_stb = 1'b1;
        sig_in = {8'd250, 8'd128, 8'd64, 8'd9};
      end
      if (cyc == 12) check("b2b_second", sig_out0, {8'd250, 8'd128, 8'd64, 8'd9});
    end

    // Reset mid-frame aborts the frame and clears gains
    check("pre_rst_u1_nonzero", (sig_out1 != 32'h0), 1'b1);
    sig_in = {4{8'd200}};
    cv_in = {4{8'd255}};
    bipolar = 1'b0;
    sample_stb = 1'b1;
    tick();
    sample_stb = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("midrst_sig_out", sig_out1, 32'h0);
    check("midrst_busy", busy1, 1'b0);
    check("midrst_out_valid", out_valid1, 1'b0);
    tick();
    rst_n = 1'b1;
    pulses = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      tick();
      if (out_valid1) pulses++;
    end
    check("midrst_no_out_valid", 64'(pulses), 64'd0);
    check("midrst_sig_out_held", sig_out1, 32'h0);

    // Slew ramp up from g=0 with SLEW_STEP=16, sample 200
    gm = 0;
    for (int f = 1; f <= 16; f++) begin
      gm = (gm + 16 > 255) ? 255 : gm + 16;
      e = (gm == 255) ? 8'd200 : 8'((200 * gm) >> 8);
      run_frame({4{8'd200}}, {4{8'd255}}, 1'b0);
      check($sformatf("slew_up_f%0d", f), sig_out1, {4{e}});
    end
    check("slew_up_f1_value", 64'((200 * 16) >> 8), 64'd12);

    // Slew ramp down to 0
    for (int f = 1; f <= 16; f++) begin
      gm = (gm - 16 < 0) ? 0 : gm - 16;
      e = 8'((200 * gm) >> 8);
      run_frame({4{8'd200}}, {4{8'd0}}, 1'b0);
      check($sformatf("slew_dn_f%0d", f), sig_out1, {4{e}});
    end
    check("slew_dn_end", sig_out1, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
